// File: rtl/branch_predictor_if.sv
// Fetch/execute-facing bundle of the branch predictor: lookup, prediction, training and redirect signals.
interface branch_predictor_if #(
    parameter int unsigned DataWidth = 32
);
    logic                 lkp_valid;
    logic [DataWidth-1:0] lkp_pc;
    logic                 pred_valid;
    logic                 pred_taken;
    logic [DataWidth-1:0] pred_target;
    logic                 upd_valid;
    logic                 upd_is_branch;
    logic [DataWidth-1:0] upd_pc;
    logic                 upd_taken;
    logic [DataWidth-1:0] upd_target;
    logic                 upd_pred_taken;
    logic [DataWidth-1:0] upd_pred_target;
    logic                 flush;
    logic [DataWidth-1:0] redirect_pc;

    // Pipeline side: issues lookups and resolved outcomes, consumes predictions and redirects
    modport master (
        output lkp_valid, lkp_pc,
        output upd_valid, upd_is_branch, upd_pc, upd_taken, upd_target,
        output upd_pred_taken, upd_pred_target,
        input  pred_valid, pred_taken, pred_target, flush, redirect_pc
    );

    modport slave (
        input  lkp_valid, lkp_pc,
        input  upd_valid, upd_is_branch, upd_pc, upd_taken, upd_target,
        input  upd_pred_taken, upd_pred_target,
        output pred_valid, pred_taken, pred_target, flush, redirect_pc
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters, registered prediction and mispredict flush/redirect.
// Optional macro BRANCH_PRED_STATS_EN adds saturating branch and mispredict counters.
module branch_predictor #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Entries   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    branch_predictor_if.slave bp
`ifdef BRANCH_PRED_STATS_EN
    ,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispredicts
`endif
);
    localparam int unsigned IdxW = $clog2(Entries);
    localparam int unsigned TagW = DataWidth - 2 - IdxW;

    typedef struct packed {
        logic                 valid;
        logic [TagW-1:0]      tag;
        logic [DataWidth-1:0] target;
        logic [1:0]           ctr;
    } btb_entry_t;

    btb_entry_t table_q [Entries];

    logic [IdxW-1:0]      lkp_idx_c;
    logic [TagW-1:0]      lkp_tag_c;
    btb_entry_t           lkp_entry_c;
    logic                 lkp_taken_c;
    logic [IdxW-1:0]      upd_idx_c;
    logic [TagW-1:0]      upd_tag_c;
    btb_entry_t           upd_entry_c;
    logic                 upd_hit_c;
    logic                 upd_en_c;
    logic                 mispredict_c;
    logic [DataWidth-1:0] redirect_c;
    logic                 unused_lkp_lsb_c;

    assign unused_lkp_lsb_c = ^bp.lkp_pc[1:0];

    // Table read for lookup and training; both see the entry as it was before this edge
    always_comb begin
        lkp_idx_c    = bp.lkp_pc[IdxW+1:2];
        lkp_tag_c    = bp.lkp_pc[DataWidth-1:IdxW+2];
        lkp_entry_c  = table_q[lkp_idx_c];
        lkp_taken_c  = lkp_entry_c.valid && (lkp_entry_c.tag == lkp_tag_c) && lkp_entry_c.ctr[1];

        upd_idx_c    = bp.upd_pc[IdxW+1:2];
        upd_tag_c    = bp.upd_pc[DataWidth-1:IdxW+2];
        upd_entry_c  = table_q[upd_idx_c];
        upd_hit_c    = upd_entry_c.valid && (upd_entry_c.tag == upd_tag_c);
        upd_en_c     = bp.upd_valid && bp.upd_is_branch;

        mispredict_c = 1'b0;
        redirect_c   = bp.upd_pc + DataWidth'(4);
        if (bp.upd_valid) begin
            if (bp.upd_is_branch) begin
                mispredict_c = (bp.upd_taken != bp.upd_pred_taken) ||
                               (bp.upd_taken && bp.upd_pred_taken &&
                                (bp.upd_target != bp.upd_pred_target));
                if (bp.upd_taken) begin
                    redirect_c = bp.upd_target;
                end
            end else begin
                // A taken prediction on a non-branch steered fetch away from the fall-through path
                mispredict_c = bp.upd_pred_taken;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < Entries; i++) begin
                table_q[IdxW'(i)] <= '{valid: 1'b0, tag: '0, target: '0, ctr: 2'b01};
            end
        end else if (upd_en_c) begin
            if (upd_hit_c) begin
                if (bp.upd_taken) begin
                    if (upd_entry_c.ctr != 2'b11) begin
                        table_q[upd_idx_c].ctr <= upd_entry_c.ctr + 2'b01;
                    end
                    table_q[upd_idx_c].target <= bp.upd_target;
                end else if (upd_entry_c.ctr != 2'b00) begin
                    table_q[upd_idx_c].ctr <= upd_entry_c.ctr - 2'b01;
                end
            end else if (bp.upd_taken) begin
                // Taken miss replaces whatever currently occupies the slot, starting weakly taken
                table_q[upd_idx_c] <= '{valid: 1'b1, tag: upd_tag_c, target: bp.upd_target, ctr: 2'b10};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp.pred_valid  <= 1'b0;
            bp.pred_taken  <= 1'b0;
            bp.pred_target <= '0;
            bp.flush       <= 1'b0;
            bp.redirect_pc <= '0;
        end else begin
            bp.pred_valid  <= bp.lkp_valid;
            bp.pred_taken  <= bp.lkp_valid && lkp_taken_c;
            bp.pred_target <= (bp.lkp_valid && lkp_taken_c) ? lkp_entry_c.target : '0;
            bp.flush       <= mispredict_c;
            if (mispredict_c) begin
                bp.redirect_pc <= redirect_c;
            end
        end
    end

`ifdef BRANCH_PRED_STATS_EN
    // Mispredicts are counted on the edge that raises their flush pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (upd_en_c && (stat_branches != 32'hFFFF_FFFF)) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (mispredict_c && (stat_mispredicts != 32'hFFFF_FFFF)) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios then randomized traffic against a table model.
// Build with BRANCH_PRED_STATS_EN defined to also check the statistics counters.
module tb_branch_predictor;
    localparam int unsigned DW      = 32;
    localparam int unsigned ENTRIES = 16;
    localparam int unsigned IDXW    = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    branch_predictor_if #(.DataWidth(DW)) bp_if ();

`ifdef BRANCH_PRED_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
    branch_predictor #(.DataWidth(DW), .Entries(ENTRIES)) dut (
        .clk(clk), .rst_n(rst_n), .bp(bp_if),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );
`else
    branch_predictor #(.DataWidth(DW), .Entries(ENTRIES)) dut (
        .clk(clk), .rst_n(rst_n), .bp(bp_if)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one record per slot, addressed by word address modulo the table size
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    int unsigned exp_branches;
    int unsigned exp_mispredicts;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned slot_of(input logic [31:0] pc);
        return (pc / 4) % ENTRIES;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(ENTRIES); i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
        exp_branches    = 0;
        exp_mispredicts = 0;
    endtask

    // One clock: drive inputs, predict outputs from the pre-edge model, then advance the model and compare
    task automatic cycle(input bit lv, input logic [31:0] lpc,
                         input bit uv, input bit ub, input logic [31:0] upc, input bit ut,
                         input logic [31:0] utgt, input bit upt, input logic [31:0] uptgt);
        int unsigned s;
        bit          hit;
        bit          e_taken;
        logic [31:0] e_target;
        bit          e_flush;
        logic [31:0] e_redirect;

        bp_if.lkp_valid       = lv;
        bp_if.lkp_pc          = lpc;
        bp_if.upd_valid       = uv;
        bp_if.upd_is_branch   = ub;
        bp_if.upd_pc          = upc;
        bp_if.upd_taken       = ut;
        bp_if.upd_target      = utgt;
        bp_if.upd_pred_taken  = upt;
        bp_if.upd_pred_target = uptgt;

        s        = slot_of(lpc);
        e_taken  = lv && m_valid[s] && (m_tag[s] == tag_of(lpc)) && (m_ctr[s] >= 2);
        e_target = e_taken ? m_tgt[s] : 32'h0;

        e_flush    = 1'b0;
        e_redirect = upc + 32'd4;
        if (uv && ub) begin
            e_flush = (ut != upt) || (ut && upt && (utgt != uptgt));
            if (ut) e_redirect = utgt;
        end else if (uv) begin
            e_flush = upt;
        end

        @(posedge clk);
        #1;

        if (uv && ub) begin
            s   = slot_of(upc);
            hit = m_valid[s] && (m_tag[s] == tag_of(upc));
            exp_branches++;
            if (hit) begin
                if (ut) begin
                    m_ctr[s] = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
                    m_tgt[s] = utgt;
                end else begin
                    m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
                end
            end else if (ut) begin
                m_valid[s] = 1'b1;
                m_tag[s]   = tag_of(upc);
                m_tgt[s]   = utgt;
                m_ctr[s]   = 2;
            end
        end
        if (e_flush) exp_mispredicts++;

        check("pred_valid", 64'(bp_if.pred_valid), 64'(lv));
        check("pred_taken", 64'(bp_if.pred_taken), 64'(e_taken));
        check("pred_target", 64'(bp_if.pred_target), 64'(e_target));
        check("flush", 64'(bp_if.flush), 64'(e_flush));
        if (e_flush) check("redirect_pc", 64'(bp_if.redirect_pc), 64'(e_redirect));
`ifdef BRANCH_PRED_STATS_EN
        check("stat_branches", 64'(stat_branches), 64'(exp_branches));
        check("stat_mispredicts", 64'(stat_mispredicts), 64'(exp_mispredicts));
`endif
    endtask

    task automatic lookup(input logic [31:0] pc);
        cycle(1'b1, pc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic train(input logic [31:0] pc, input bit taken, input logic [31:0] tgt,
                         input bit ptaken, input logic [31:0] ptgt);
        cycle(1'b0, 32'h0, 1'b1, 1'b1, pc, taken, tgt, ptaken, ptgt);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_pred_valid"}, 64'(bp_if.pred_valid), 64'd0);
        check({tag, "_pred_taken"}, 64'(bp_if.pred_taken), 64'd0);
        check({tag, "_pred_target"}, 64'(bp_if.pred_target), 64'd0);
        check({tag, "_flush"}, 64'(bp_if.flush), 64'd0);
        check({tag, "_redirect_pc"}, 64'(bp_if.redirect_pc), 64'd0);
    endtask

    task automatic drive_idle();
        bp_if.lkp_valid       = 1'b0;
        bp_if.lkp_pc          = '0;
        bp_if.upd_valid       = 1'b0;
        bp_if.upd_is_branch   = 1'b0;
        bp_if.upd_pc          = '0;
        bp_if.upd_taken       = 1'b0;
        bp_if.upd_target      = '0;
        bp_if.upd_pred_taken  = 1'b0;
        bp_if.upd_pred_target = '0;
    endtask

    initial begin
        logic [31:0] pool_tgt;
        logic [31:0] upc;
        logic [31:0] lpc;
        bit          ub;
        bit          ut;

        n_checks = 0;
        n_errors = 0;
        drive_idle();
        model_reset();
        rst_n = 1'b0;
        #12;
        check_cleared("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Cold lookup misses
        lookup(32'h0000_0100);
        // Taken miss allocates and flushes to the target, then predicts it
        train(32'h0000_0100, 1'b1, 32'h0000_0080, 1'b0, 32'h0);
        lookup(32'h0000_0100);
        // Walk the counter down to zero and past it
        train(32'h0000_0100, 1'b0, 32'h0, 1'b1, 32'h0000_0080);
        train(32'h0000_0100, 1'b0, 32'h0, 1'b0, 32'h0);
        train(32'h0000_0100, 1'b0, 32'h0, 1'b0, 32'h0);
        lookup(32'h0000_0100);
        train(32'h0000_0100, 1'b0, 32'h0, 1'b0, 32'h0);
        train(32'h0000_0100, 1'b1, 32'h0000_0080, 1'b0, 32'h0);
        lookup(32'h0000_0100);
        // Aliasing within slot 0
        train(32'h0000_0140, 1'b1, 32'h0000_0200, 1'b0, 32'h0);
        lookup(32'h0000_0100);
        lookup(32'h0000_0140);

        // Asynchronous reset mid-operation, away from any clock edge
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_cleared("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        lookup(32'h0000_0140);

        // Lookup and allocating update in the same cycle read the old entry
        cycle(1'b1, 32'h0000_0100, 1'b1, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0300, 1'b0, 32'h0);
        lookup(32'h0000_0100);
        // Fall-through redirect wraps around the address space
        train(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0000_1000);
        // Taken prediction on a non-branch, back to back with a target mismatch
        cycle(1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 32'h0, 1'b1, 32'h0000_0300);
        train(32'h0000_0100, 1'b1, 32'h0000_0400, 1'b1, 32'h0000_0300);
        lookup(32'h0000_0100);
        // Correct prediction: no flush
        train(32'h0000_0100, 1'b1, 32'h0000_0400, 1'b1, 32'h0000_0400);

        // Randomized traffic over a small PC/target pool so hits, aliases and saturation are frequent
        for (int n = 0; n < 3000; n++) begin
            lpc = ($urandom_range(0, 1) ? 32'h0001_0000 : 32'h0) |
                  32'($urandom_range(0, 31) << 2) | 32'($urandom_range(0, 3));
            upc = ($urandom_range(0, 1) ? 32'h0001_0000 : 32'h0) | 32'($urandom_range(0, 31) << 2);
            if ($urandom_range(0, 49) == 0) upc = 32'hFFFF_FFFC;
            pool_tgt = 32'($urandom_range(0, 7) << 4);
            ub = ($urandom_range(0, 4) != 0);
            ut = ub && ($urandom_range(0, 2) != 0);
            cycle(1'($urandom_range(0, 1)), lpc,
                  1'($urandom_range(0, 1)), ub, upc, ut, pool_tgt,
                  1'($urandom_range(0, 1)), 32'($urandom_range(0, 7) << 4));
        end

        drive_idle();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage dynamic branch predictor: a direct-mapped branch target buffer (BTB) with one 2-bit saturating counter per entry.
- Looks up each fetch PC and returns a registered taken/target prediction one cycle later.
- Trained from execute by the resolved branch outcome, i.e. the Branch bit from the execute-stage comparator.
- Detects mispredictions and drives a registered flush/redirect to the PC and pipeline control.

Parameters:
- DataWidth, 32, PC/target width.
- Entries, 16, BTB entries; power of two, 2..256.
- IdxW, $clog2(Entries), index width (localparam).
- TagW, DataWidth-2-IdxW, tag width (localparam).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- lkp_valid  in  1  fetch PC valid this cycle
- lkp_pc  in  DataWidth  fetch PC
- pred_valid  out  1  prediction valid (lkp_valid delayed 1 cycle)
- pred_taken  out  1  predicted taken
- pred_target  out  DataWidth  predicted target; 0 when not taken
- upd_valid  in  1  execute has a resolved instruction this cycle
- upd_is_branch  in  1  the resolved instruction is a conditional branch
- upd_pc  in  DataWidth  PC of the resolved instruction
- upd_taken  in  1  actual outcome (comparator Branch)
- upd_target  in  DataWidth  actual taken target
- upd_pred_taken  in  1  prediction carried down the pipe with the instruction
- upd_pred_target  in  DataWidth  predicted target carried down the pipe
- flush  out  1  mispredict: kill younger instructions
- redirect_pc  out  DataWidth  correct next PC, qualified by flush

Behaviour:
- Index = pc[IdxW+1:2]; tag = pc[DataWidth-1:IdxW+2]; pc[1:0] ignored.
- Entry fields: valid, tag, target, ctr[1:0]. ctr >= 2 means predict taken.
- Reset (async, rst_n low):
  - all valid=0, ctr=2'b01, tag/target=0.
  - pred_valid=0, pred_taken=0, pred_target=0, flush=0, redirect_pc=0.
- Lookup, 1-cycle latency:
  - Cycle N: lkp_valid=1 with lkp_pc.
  - Cycle N+1: pred_valid=1; pred_taken = hit && ctr>=2; pred_target = entry target if pred_taken, else 0.
  - hit = valid && tag match.
  - lkp_valid=0 gives pred_valid=0 and pred_taken=0 next cycle.
- Update, applied at the clock edge when upd_valid && upd_is_branch:
  - Hit: ctr increments (saturating at 3) if taken, decrements (saturating at 0) if not; target overwritten with upd_target if taken.
  - Miss, taken: allocate the entry (replace the existing one): valid=1, tag, target, ctr=2'b10.
  - Miss, not taken: no allocation, table unchanged.
  - upd_valid && !upd_is_branch: table unchanged.
- Mispredict detection, registered, flush asserted the cycle after update:
  - Branch mispredict: upd_taken != upd_pred_taken, or upd_taken && upd_pred_taken && upd_target != upd_pred_target.
  - Non-branch: upd_pred_taken=1 on a non-branch is a mispredict; redirect to upd_pc+4.
  - redirect_pc = upd_taken ? upd_target : upd_pc+4 (DataWidth arithmetic, wraps modulo 2^DataWidth).
  - flush is a 1-cycle pulse per mispredict; back-to-back mispredicts give consecutive pulses.
- Same-cycle lookup and update to the same index: lookup reads the pre-update entry (read-before-write, no bypass).
- rst_n asserted mid-operation clears the table and outputs immediately. The first lookup after release returns not-taken.

Optional Feature:
- Macro BRANCH_PRED_STATS_EN.
- Defined: adds outputs stat_branches and stat_mispredicts, 32-bit each.
  - stat_branches increments on each upd_valid && upd_is_branch.
  - stat_mispredicts increments on each flush pulse.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, then lookup 0x0000_0100 -> next cycle pred_valid=1, pred_taken=0, pred_target=0; flush=0.
- Update pc=0x100, taken, target=0x80, pred_taken=0 -> flush=1 for one cycle, redirect_pc=0x80; a following lookup of 0x100 -> pred_taken=1, pred_target=0x80.
- Three not-taken updates on pc=0x100 from ctr=2 -> ctr reaches 0; lookup -> pred_taken=0; a fourth not-taken update keeps ctr=0.
- Aliasing, Entries=16: 0x100 and 0x140 share index 0; allocate 0x140 taken to 0x200 -> lookup 0x100 misses (pred_taken=0); lookup 0x140 -> target 0x200.
- Same cycle: update 0x100 taken while looking up 0x100 (entry initially invalid) -> that lookup pred_taken=0; the next lookup pred_taken=1.
- Update pc=0xFFFF_FFFC, not taken, pred_taken=1 -> flush=1, redirect_pc=0x0000_0000 (wrap); with BRANCH_PRED_STATS_EN: stat_mispredicts +1, stat_branches +1.
